// File: rtl/his_builder_fsm.sv
// ============================================================================
// his_builder_fsm : per-pixel coarse histogram builder and peak finder (dToF).
// Optional macro HISB_IGNORE_SAT_EN: all-ones word is a no-photon marker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module his_builder_fsm #(
    parameter int NP                = 10,
    parameter int PIXEL_NUM_PER_RAM = 3,
    parameter int HITS_PER_PIXEL    = 2,
    parameter int ACQ_NUM           = 2,
    parameter int BIN_BITS          = 4,
    parameter int CNT_W             = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          wrEn,
    input  logic [NP-1:0] data,
    output logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM]
);

    localparam int NBINS = 1 << BIN_BITS;
    localparam int HIT_W = (HITS_PER_PIXEL > 1) ? $clog2(HITS_PER_PIXEL) : 1;
    localparam int PIX_W = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
    localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

    localparam logic [HIT_W-1:0]       C_HIT_LAST = HIT_W'(HITS_PER_PIXEL - 1);
    localparam logic [PIX_W-1:0]       C_PIX_LAST = PIX_W'(PIXEL_NUM_PER_RAM - 1);
    localparam logic [ACQ_W-1:0]       C_ACQ_LAST = ACQ_W'(ACQ_NUM - 1);
    localparam logic [BIN_BITS-1:0]    C_BIN_LAST = '1;
    localparam logic [CNT_W-1:0]       C_CNT_MAX  = '1;
    localparam logic [NP-BIN_BITS-1:0] C_CENTRE   = (NP-BIN_BITS)'(1) << (NP - BIN_BITS - 1);

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [HIT_W-1:0]    r_hit;
    logic [PIX_W-1:0]    r_pix;
    logic [ACQ_W-1:0]    r_acq;
    logic [BIN_BITS-1:0] r_scan_bin;
    logic [CNT_W-1:0]    r_cnt    [PIXEL_NUM_PER_RAM][NBINS];
    logic [CNT_W-1:0]    r_max    [PIXEL_NUM_PER_RAM];
    logic [BIN_BITS-1:0] r_maxbin [PIXEL_NUM_PER_RAM];

    logic [BIN_BITS-1:0] w_bin;
    logic                w_count_en;
    logic                w_data_unused;

    assign w_bin         = data[NP-1 -: BIN_BITS];
    assign w_data_unused = ^data[NP-BIN_BITS-1:0];

`ifdef HISB_IGNORE_SAT_EN
    assign w_count_en = (data != {NP{1'b1}});
`else
    assign w_count_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            r_state    <= ST_ACC;
            r_hit      <= '0;
            r_pix      <= '0;
            r_acq      <= '0;
            r_scan_bin <= '0;
            for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                r_max[p]      <= '0;
                r_maxbin[p]   <= '0;
                peakResult[p] <= '0;
                for (int b = 0; b < NBINS; b++) begin
                    r_cnt[p][b] <= '0;
                end
            end
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (wrEn) begin
                        if (w_count_en && (r_cnt[r_pix][w_bin] != C_CNT_MAX)) begin
                            r_cnt[r_pix][w_bin] <= r_cnt[r_pix][w_bin] + 1'b1;
                        end
                        // Pixel-major ordering: hit index is the fastest-moving.
                        if (r_hit == C_HIT_LAST) begin
                            r_hit <= '0;
                            if (r_pix == C_PIX_LAST) begin
                                r_pix <= '0;
                                if (r_acq == C_ACQ_LAST) begin
                                    r_acq      <= '0;
                                    r_scan_bin <= '0;
                                    r_state    <= ST_SCAN;
                                    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                                        r_max[p]    <= '0;
                                        r_maxbin[p] <= '0;
                                    end
                                end else begin
                                    r_acq <= r_acq + 1'b1;
                                end
                            end else begin
                                r_pix <= r_pix + 1'b1;
                            end
                        end else begin
                            r_hit <= r_hit + 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    // Strictly-greater update keeps the lowest bin on ties.
                    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                        if (r_cnt[p][r_scan_bin] > r_max[p]) begin
                            r_max[p]    <= r_cnt[p][r_scan_bin];
                            r_maxbin[p] <= r_scan_bin;
                        end
                    end
                    r_scan_bin <= r_scan_bin + 1'b1;
                    if (r_scan_bin == C_BIN_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                        peakResult[p] <= (r_max[p] == '0) ? '0 : {r_maxbin[p], C_CENTRE};
                        for (int b = 0; b < NBINS; b++) begin
                            r_cnt[p][b] <= '0;
                        end
                    end
                    r_state <= ST_ACC;
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_his_builder_fsm.sv
// ============================================================================
// tb_his_builder_fsm : directed bench for his_builder_fsm.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_his_builder_fsm;

    logic       clk;
    logic       res;
    logic       wrEn;
    logic [9:0] data;
    logic [9:0] peakResult [3];

    int total;
    int fails;

    // Frame A: pixel-major, acquisition 0 then acquisition 1.
    logic [9:0] frame_a [12];
    logic [9:0] frame_b [12];

    his_builder_fsm dut (
        .clk       (clk),
        .res       (res),
        .wrEn      (wrEn),
        .data      (data),
        .peakResult(peakResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check3(input string tag, input logic [9:0] e0, input logic [9:0] e1,
                          input logic [9:0] e2);
        logic [9:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int p = 0; p < 3; p++) begin
            total++;
            assert (peakResult[p] === e[p]) else begin
                fails++;
                $error("FAIL %s pix%0d observed=%0d expected=%0d", tag, p, peakResult[p], e[p]);
            end
        end
    endtask

    task automatic get_word(input int sel, input int i, output logic [9:0] w);
        if (sel == 0)      w = frame_a[i];
        else if (sel == 1) w = frame_b[i];
        else               w = 10'd1023;
    endtask

    // Ends at the negedge following the edge that accepted the last word.
    task automatic send_frame(input int sel, input bit gaps);
        logic [9:0] w;
        for (int i = 0; i < 12; i++) begin
            get_word(sel, i, w);
            @(negedge clk);
            wrEn = 1'b1;
            data = w;
            if (gaps && i < 11) begin
                @(negedge clk);
                wrEn = 1'b0;
                repeat (i % 4) @(negedge clk);
            end
        end
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    // Checks the old value one edge before the update (E16) and the new one at E17.
    task automatic finish_frame(input string tag, input bit junk,
                                input logic [9:0] p0, input logic [9:0] p1, input logic [9:0] p2,
                                input logic [9:0] n0, input logic [9:0] n1, input logic [9:0] n2);
        if (junk) begin
            wrEn = 1'b1;
            data = 10'd1000;
        end
        repeat (16) @(posedge clk);
        #1 check3({tag, "_pre"}, p0, p1, p2);
        @(posedge clk);
        #1 check3({tag, "_post"}, n0, n1, n2);
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    initial begin
        total = 0;
        fails = 0;
        res   = 1'b1;
        wrEn  = 1'b0;
        data  = '0;
        frame_a = '{10'd100, 10'd110, 10'd650, 10'd660, 10'd70, 10'd130,
                    10'd120, 10'd400, 10'd20,  10'd670, 10'd75, 10'd135};
        frame_b = '{10'd900, 10'd900, 10'd300, 10'd310, 10'd1000, 10'd500,
                    10'd900, 10'd5,   10'd0,   10'd1,   10'd1000, 10'd500};

        repeat (2) @(negedge clk);
        res = 1'b0;
        check3("reset", 10'd0, 10'd0, 10'd0);

        send_frame(0, 1'b0);
        finish_frame("frameA", 1'b0, 10'd0, 10'd0, 10'd0, 10'd96, 10'd672, 10'd96);

        send_frame(1, 1'b1);
        finish_frame("frameB_gap", 1'b0, 10'd96, 10'd672, 10'd96, 10'd928, 10'd32, 10'd480);

        send_frame(0, 1'b1);
        finish_frame("frameA_gap", 1'b0, 10'd928, 10'd32, 10'd480, 10'd96, 10'd672, 10'd96);

        send_frame(1, 1'b0);
        finish_frame("frameB_junk", 1'b1, 10'd96, 10'd672, 10'd96, 10'd928, 10'd32, 10'd480);

        repeat (10) @(negedge clk);
        check3("hold", 10'd928, 10'd32, 10'd480);

        send_frame(0, 1'b0);
        finish_frame("after_junk", 1'b0, 10'd928, 10'd32, 10'd480, 10'd96, 10'd672, 10'd96);

        send_frame(2, 1'b0);
`ifdef HISB_IGNORE_SAT_EN
        finish_frame("all_ones", 1'b0, 10'd96, 10'd672, 10'd96, 10'd0, 10'd0, 10'd0);
`else
        finish_frame("all_ones", 1'b0, 10'd96, 10'd672, 10'd96, 10'd992, 10'd992, 10'd992);
`endif

        send_frame(0, 1'b0);
        finish_frame("pre_rst", 1'b0, peakResult[0], peakResult[1], peakResult[2],
                     10'd96, 10'd672, 10'd96);

        send_frame(1, 1'b0);
        repeat (5) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        check3("midscan_rst", 10'd0, 10'd0, 10'd0);
        repeat (20) @(negedge clk);
        check3("rst_idle", 10'd0, 10'd0, 10'd0);

        send_frame(1, 1'b0);
        finish_frame("after_rst", 1'b0, 10'd0, 10'd0, 10'd0, 10'd928, 10'd32, 10'd480);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/his_builder_fsm.md
Name: his_builder_fsm

Overview:
- Per-pixel coarse histogram builder and peak finder for the dToF pipeline.
- Consumes a stream of Np-bit TDC timestamps for one RAM group of pixels and bins each timestamp into a per-pixel coarse histogram.
- After a fixed number of acquisitions, scans all histograms, publishes one peak timestamp per pixel, then clears for the next frame.
- Sits between the TDC/rough-data stage and the fine peak-refinement stage.

Parameters:
- NP, 10, timestamp width (matches `Np).
- PIXEL_NUM_PER_RAM, 3, pixels handled by this instance.
- HITS_PER_PIXEL, 2, consecutive words per pixel per acquisition.
- ACQ_NUM, 2, acquisitions accumulated before a peak search.
- BIN_BITS, 4, coarse bin index = data[NP-1 -: BIN_BITS]; 2^BIN_BITS bins per pixel.
- CNT_W, 8, histogram counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- res  in  1  reset, synchronous, active-high.
- wrEn  in  1  data-valid strobe; data is accepted on any edge where wrEn=1 in state ACC.
- data  in  NP  TDC timestamp.
- peakResult  out  unpacked array [PIXEL_NUM_PER_RAM-1:0] of NP bits  registered per-pixel peak timestamp.

Behaviour:
- Reset (res=1 at an edge):
  - state <- ACC.
  - All counters <- 0; hit index, pixel index and acquisition index <- 0.
  - All peakResult <- 0.
  - Reset overrides everything, including mid-SCAN.
- Word ordering, pixel-major:
  - HITS_PER_PIXEL words for pixel 0, then pixel 1, ... up to pixel P-1; this completes one acquisition.
  - Indices advance only on accepted words.
- ACC:
  - On an accepted word, the counter [pixel][bin] increments at the same edge.
  - Counters saturate at 2^CNT_W-1.
  - When the accepted word is the last word of acquisition ACQ_NUM-1: state -> SCAN and all indices -> 0.
- SCAN:
  - One bin per cycle, bins 0..2^BIN_BITS-1 in order, all pixels in parallel.
  - Per pixel, keeps a running max count and its bin.
  - Update only on strictly greater count, so ties resolve to the lowest bin.
  - After bin 2^BIN_BITS-1: state -> DONE.
- DONE (1 cycle):
  - Each pixel's peakResult <- (maxBin << (NP-BIN_BITS)) | (1 << (NP-BIN_BITS-1)), i.e. the bin centre.
  - If max count = 0, peakResult <- 0.
  - Clear all counters; state -> ACC.
- Latency: if the last word is accepted at edge E0, SCAN occupies E1..E16 and peakResult updates at E17 (2^BIN_BITS+1 edges after E0). New words are accepted from E18.
- wrEn during SCAN/DONE: words are dropped; indices are not advanced.
- peakResult holds its value between frames.

Optional Feature:
- Macro HISB_IGNORE_SAT_EN.
- Defined: data == all-ones (1023) is a no-photon marker. It advances the word/pixel indices but increments no counter.
- Undefined: all-ones is binned normally into the top bin.

Test Plan:
- Reset: res=1 for 2 cycles -> all peakResult=0; a subsequent frame behaves normally.
- 2 acquisitions:
  - Pixel0 gets 100,110 then 120,400 -> 96 (bin 1, count 3).
  - Pixel1 gets 650,660 then 20,670 -> 672 (bin 10).
  - Pixel2 gets 70,130 then 75,135 -> tie between bins 1 and 2 -> 96.
  - peakResult updates exactly 17 edges after the last word.
- Same stream with wrEn=0 gaps of 1-4 cycles between words -> identical results and timing relative to the last word.
- All pixels receive 1023 only:
  - With HISB_IGNORE_SAT_EN -> all peakResult=0.
  - Without it -> all peakResult=992.
- Words driven with wrEn=1 during SCAN -> ignored; the next frame's results match a clean run.
- res asserted mid-SCAN -> peakResult=0, state ACC; a following full frame produces the correct peaks.
